// File: rtl/ball_bounce_ctrl_pkg.sv
// Shared definitions for the ball direction controller: direction encodings
// and the cooldown counter width.
package ball_bounce_ctrl_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int COOLDOWN_W = 4;

endpackage

// File: rtl/ball_bounce_ctrl_axis.sv
// One bounce axis: two sticky hit flags, the set/hold decision and the changed strobe.
// The per-axis cooldown counter exists only when BOUNCE_COOLDOWN_EN is defined.
module ball_bounce_ctrl_axis
  import ball_bounce_ctrl_pkg::*;
#(
  parameter logic p_DIR_INIT = 1'b1,
  parameter logic p_A_DIR    = 1'b1,
  parameter logic p_B_DIR    = 1'b0,
  parameter int   p_COOLDOWN = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_vblank,
  input  logic i_frame_edge,
  input  logic i_hit_a,
  input  logic i_hit_b,
  output logic o_dir,
  output logic o_changed
);

  logic flag_a_q, flag_a_d;
  logic flag_b_q, flag_b_d;
  logic dir_q, dir_d;
  logic changed_q, changed_d;
  logic cd_ok;

`ifdef BOUNCE_COOLDOWN_EN
  logic [COOLDOWN_W-1:0] cd_q, cd_d;

  assign cd_ok = (cd_q == '0);

  // A reload takes priority over the countdown on the same frame edge.
  always_comb begin
    cd_d = cd_q;
    if (changed_d)
      cd_d = COOLDOWN_W'(p_COOLDOWN);
    else if (i_frame_edge && !cd_ok)
      cd_d = cd_q - COOLDOWN_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) cd_q <= '0;
    else         cd_q <= cd_d;
  end
`else
  assign cd_ok = 1'b1;
`endif

  always_comb begin
    flag_a_d  = flag_a_q;
    flag_b_d  = flag_b_q;
    dir_d     = dir_q;
    changed_d = 1'b0;
    if (i_frame_edge) begin
      flag_a_d = 1'b0;
      flag_b_d = 1'b0;
      if (cd_ok && (flag_a_q ^ flag_b_q)) begin
        dir_d     = flag_a_q ? p_A_DIR : p_B_DIR;
        changed_d = (dir_d != dir_q);
      end
    end else if (!i_vblank) begin
      flag_a_d = flag_a_q | i_hit_a;
      flag_b_d = flag_b_q | i_hit_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flag_a_q  <= 1'b0;
      flag_b_q  <= 1'b0;
      dir_q     <= p_DIR_INIT;
      changed_q <= 1'b0;
    end else begin
      flag_a_q  <= flag_a_d;
      flag_b_q  <= flag_b_d;
      dir_q     <= dir_d;
      changed_q <= changed_d;
    end
  end

  assign o_dir     = dir_q;
  assign o_changed = changed_q;

endmodule

// File: rtl/ball_bounce_ctrl.sv
// Ball direction controller: collects wall/paddle hits during the active scan and
// commits direction changes at the rising edge of VBlank. Macro: BOUNCE_COOLDOWN_EN.
module ball_bounce_ctrl
  import ball_bounce_ctrl_pkg::*;
#(
  parameter logic p_VDIR_INIT = 1'b1,
  parameter logic p_HDIR_INIT = 1'b1,
  parameter int   p_COOLDOWN  = 2
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_VBlank,
  input  logic i_Ball_Video,
  input  logic i_Wall_Top,
  input  logic i_Wall_Bot,
  input  logic i_Paddle_L,
  input  logic i_Paddle_R,
  output logic o_VDir,
  output logic o_HDir,
  output logic o_Hit
);

  logic vb_q, vb_d;
  logic frame_edge;
  logic changed_v, changed_h;

  // vb_q resets high so a VBlank already asserted at release is not seen as an edge.
  assign vb_d       = i_VBlank;
  assign frame_edge = i_VBlank & ~vb_q;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) vb_q <= 1'b1;
    else         vb_q <= vb_d;
  end

  ball_bounce_ctrl_axis #(
    .p_DIR_INIT (p_VDIR_INIT),
    .p_A_DIR    (DIR_DOWN),
    .p_B_DIR    (DIR_UP),
    .p_COOLDOWN (p_COOLDOWN)
  ) u_axis_v (
    .i_clk        (i_Clk),
    .i_reset      (i_Reset),
    .i_vblank     (i_VBlank),
    .i_frame_edge (frame_edge),
    .i_hit_a      (i_Ball_Video & i_Wall_Top),
    .i_hit_b      (i_Ball_Video & i_Wall_Bot),
    .o_dir        (o_VDir),
    .o_changed    (changed_v)
  );

  ball_bounce_ctrl_axis #(
    .p_DIR_INIT (p_HDIR_INIT),
    .p_A_DIR    (DIR_RIGHT),
    .p_B_DIR    (DIR_LEFT),
    .p_COOLDOWN (p_COOLDOWN)
  ) u_axis_h (
    .i_clk        (i_Clk),
    .i_reset      (i_Reset),
    .i_vblank     (i_VBlank),
    .i_frame_edge (frame_edge),
    .i_hit_a      (i_Ball_Video & i_Paddle_L),
    .i_hit_b      (i_Ball_Video & i_Paddle_R),
    .o_dir        (o_HDir),
    .o_changed    (changed_h)
  );

  assign o_Hit = changed_v | changed_h;

endmodule

// File: tb/tb_ball_bounce_ctrl.sv
// Directed bench for ball_bounce_ctrl; expected values are hand-derived per frame.
module tb_ball_bounce_ctrl;

  logic clk = 1'b0;
  logic reset, vblank, ball, wall_top, wall_bot, pad_l, pad_r;
  logic vdir, hdir, hit;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef BOUNCE_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ball_bounce_ctrl #(
    .p_VDIR_INIT (1'b1),
    .p_HDIR_INIT (1'b1),
    .p_COOLDOWN  (2)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (reset),
    .i_VBlank     (vblank),
    .i_Ball_Video (ball),
    .i_Wall_Top   (wall_top),
    .i_Wall_Bot   (wall_bot),
    .i_Paddle_L   (pad_l),
    .i_Paddle_R   (pad_r),
    .o_VDir       (vdir),
    .o_HDir       (hdir),
    .o_Hit        (hit)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_vid(input logic b, input logic t, input logic bo, input logic l, input logic r);
    ball = b; wall_top = t; wall_bot = bo; pad_l = l; pad_r = r;
  endtask

  // One active period with 4 clocks of the given video, then VBlank rises.
  // Checks the committed directions and that o_Hit lasts exactly one clock.
  task automatic frame(input string tag, input logic b, input logic t, input logic bo,
                       input logic l, input logic r,
                       input logic ev, input logic eh, input logic ehit);
    @(negedge clk) vblank = 1'b0;
    repeat (3) @(negedge clk);
    set_vid(b, t, bo, l, r);
    repeat (4) @(negedge clk);
    set_vid(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    vblank = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".vdir"}, vdir, ev);
    chk({tag, ".hdir"}, hdir, eh);
    chk({tag, ".hit"},  hit,  ehit);
    @(posedge clk); #1;
    chk({tag, ".hit_off"}, hit, 1'b0);
    chk({tag, ".vhold"}, vdir, ev);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; vblank = 1'b1;
    set_vid(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.vdir", vdir, 1'b1);
    chk("rst.hdir", hdir, 1'b1);
    chk("rst.hit",  hit,  1'b0);
    @(negedge clk) reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst.release_hit", hit, 1'b0);
    end

    frame("bot_hit",   1, 0, 1, 0, 0, 1'b0, 1'b1, 1'b1);
    frame("agree_bot", 1, 0, 1, 0, 0, 1'b0, 1'b1, 1'b0);

    frame("cd_f0_right", 1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b1);
    frame("cd_f1_left",  1, 0, 0, 1, 0, 1'b0, CD_EN ? 1'b0 : 1'b1, CD_EN ? 1'b0 : 1'b1);
    frame("cd_f2_left",  1, 0, 0, 1, 0, 1'b0, CD_EN ? 1'b0 : 1'b1, 1'b0);
    frame("cd_f3_left",  1, 0, 0, 1, 0, 1'b0, 1'b1, CD_EN ? 1'b1 : 1'b0);

    // Hits during VBlank must not accumulate; walls lit without the ball are not hits.
    @(negedge clk) set_vid(1, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    set_vid(0, 0, 0, 0, 0);
    frame("blank_hit", 0, 1, 0, 0, 1, 1'b0, 1'b1, 1'b0);

    frame("top_and_bot", 1, 1, 1, 0, 0, 1'b0, 1'b1, 1'b0);
    frame("set_left",    1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b1);
    frame("idle1",       0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    frame("idle2",       0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    frame("top_and_left", 1, 1, 0, 1, 0, 1'b1, 1'b1, 1'b1);

    // Mid-frame reset: the bottom hit gathered before reset must be discarded.
    frame("pre_rst_left", 1, 0, 0, 0, 1, 1'b1, CD_EN ? 1'b1 : 1'b0, CD_EN ? 1'b0 : 1'b1);
    @(negedge clk) vblank = 1'b0;
    repeat (2) @(negedge clk);
    set_vid(1, 0, 1, 0, 0);
    repeat (4) @(negedge clk);
    set_vid(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    @(posedge clk); #1;
    chk("midrst.vdir", vdir, 1'b1);
    chk("midrst.hdir", hdir, 1'b1);
    chk("midrst.hit",  hit,  1'b0);
    @(posedge clk); #1;
    chk("midrst.hit_off", hit, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
